// File: rtl/lcd_pkg.sv
// Shared constants and encodings for the HD44780 4-bit read and write drivers.
// Timing defaults assume a 20 ns system clock.
package lcd_pkg;

  localparam int T_AS_DEF     = 2;
  localparam int T_PW_DEF     = 12;
  localparam int T_EL_DEF     = 13;
  localparam int POLL_MAX_DEF = 5000;
  localparam int CNT_W_DEF    = 16;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_SETUP = 3'd1,
    RD_EH_HI = 3'd2,
    RD_EL_HI = 3'd3,
    RD_EH_LO = 3'd4,
    RD_EL_LO = 3'd5,
    RD_DONE  = 3'd6
  } rd_state_e;

  function automatic logic rd_bus_owned(rd_state_e s);
    return (s == RD_SETUP) || (s == RD_EH_HI) || (s == RD_EL_HI) ||
           (s == RD_EH_LO) || (s == RD_EL_LO);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with a zero flag; one instance times every phase of
// an LCD bus cycle. Loading N-1 makes the owning state last N cycles.
module lcd_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 4-bit read engine: single BF/AC or data-RAM reads, or busy-flag
// polling with a bounded retry count. Releases DB7..DB4 while the LCD drives them.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = T_AS_DEF,
  parameter int T_PW     = T_PW_DEF,
  parameter int T_EL     = T_EL_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       mode_poll,
  input  logic       regsel,
  output logic       ready,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       timeout,
  input  logic [3:0] lcd_data_in,
  output logic       lcd_en,
  output logic       lcd_regsel,
  output logic       lcd_r1w0,
  output logic       lcd_data_oe
);

  if (T_AS < 1 || T_PW < 1 || T_EL < 1) begin : g_bad_timing
    $error("lcd_reader: T_AS, T_PW and T_EL must all be at least 1");
  end

  if (longint'(POLL_MAX) >= (longint'(1) << CNT_W) || POLL_MAX < 1) begin : g_bad_poll
    $error("lcd_reader: POLL_MAX must be in 1 .. 2**CNT_W-1");
  end

  if (longint'(T_AS) > (longint'(1) << CNT_W) ||
      longint'(T_PW) > (longint'(1) << CNT_W) ||
      longint'(T_EL) > (longint'(1) << CNT_W)) begin : g_bad_width
    $error("lcd_reader: timing parameters do not fit the CNT_W timer");
  end

  localparam logic [CNT_W-1:0] AS_LD    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_LD    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] EL_LD    = CNT_W'(T_EL - 1);
  localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);

  rd_state_e        state;
  rd_state_e        next_state;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;

  logic             alive;
  logic             rs_q;
  logic             poll_q;
  logic [3:0]       nib_hi;
  logic [3:0]       nib_lo;
  logic [CNT_W-1:0] poll_cnt;
  logic [CNT_W-1:0] poll_inc;
  logic             accept;
  logic             finish;

  assign poll_inc = poll_cnt + CNT_W'(1);
  assign accept   = (state == RD_IDLE) && (next_state == RD_SETUP);
  assign finish   = (state != RD_DONE) && (next_state == RD_DONE);

  lcd_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every timed state is entered with its duration minus one loaded into the timer.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state)
      RD_IDLE: begin
        if (start && alive) begin
          next_state = RD_SETUP;
          timer_load = 1'b1;
          timer_val  = AS_LD;
        end
      end
      RD_SETUP: begin
        if (timer_zero) begin
          next_state = RD_EH_HI;
          timer_load = 1'b1;
          timer_val  = PW_LD;
        end
      end
      RD_EH_HI: begin
        if (timer_zero) begin
          next_state = RD_EL_HI;
          timer_load = 1'b1;
          timer_val  = EL_LD;
        end
      end
      RD_EL_HI: begin
        if (timer_zero) begin
          next_state = RD_EH_LO;
          timer_load = 1'b1;
          timer_val  = PW_LD;
        end
      end
      RD_EH_LO: begin
        if (timer_zero) begin
          next_state = RD_EL_LO;
          timer_load = 1'b1;
          timer_val  = EL_LD;
        end
      end
      RD_EL_LO: begin
        if (timer_zero) begin
          if (!poll_q || !nib_hi[3] || (poll_inc == POLL_LIM)) begin
            next_state = RD_DONE;
          end else begin
            next_state = RD_EH_HI;
            timer_load = 1'b1;
            timer_val  = PW_LD;
          end
        end
      end
      RD_DONE: next_state = RD_IDLE;
      default: next_state = RD_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    done        = 1'b0;
    lcd_en      = 1'b0;
    lcd_regsel  = RS_CMD;
    lcd_r1w0    = 1'b0;
    lcd_data_oe = 1'b1;
    if (rd_bus_owned(state)) begin
      lcd_r1w0    = 1'b1;
      lcd_regsel  = rs_q;
      lcd_data_oe = 1'b0;
      lcd_en      = (state == RD_EH_HI) || (state == RD_EH_LO);
    end
    unique case (state)
      RD_IDLE: ready = alive;
      RD_DONE: done  = 1'b1;
      default: ;
    endcase
  end

  // A busy flag still set on the way into DONE can only mean the poll limit was hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive    <= 1'b0;
      rs_q     <= RS_CMD;
      poll_q   <= 1'b0;
      nib_hi   <= '0;
      nib_lo   <= '0;
      poll_cnt <= '0;
      rd_data  <= 8'h00;
      timeout  <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        rs_q     <= mode_poll ? RS_CMD : regsel;
        poll_q   <= mode_poll;
        poll_cnt <= '0;
      end
      if (state == RD_EH_HI && timer_zero) begin
        nib_hi <= lcd_data_in;
      end
      if (state == RD_EH_LO && timer_zero) begin
        nib_lo <= lcd_data_in;
      end
      if (state == RD_EL_LO && timer_zero && poll_q) begin
        poll_cnt <= poll_inc;
      end
      if (finish) begin
        rd_data <= {nib_hi, nib_lo};
        timeout <= poll_q & nib_hi[3];
      end
    end
  end

endmodule
